// File: rtl/rr_arbiter8_n.sv
// rr_arbiter8_n: round-robin arbiter for 8 requesters sharing one N-bit valid/ready channel.
// Define RR_ARB_FIXED_PRIO_EN to switch to fixed priority, where the lowest index wins.
module mux8_1_n #(
   parameter int N = 4
) (
   input  logic [N-1:0] d0,
   input  logic [N-1:0] d1,
   input  logic [N-1:0] d2,
   input  logic [N-1:0] d3,
   input  logic [N-1:0] d4,
   input  logic [N-1:0] d5,
   input  logic [N-1:0] d6,
   input  logic [N-1:0] d7,
   input  logic [2:0]   sel,
   output logic [N-1:0] y
);
   assign y = sel[2] ? (sel[1] ? (sel[0] ? d7 : d6) : (sel[0] ? d5 : d4))
                     : (sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0));
endmodule

module rr_arbiter8_n #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   req,
   input  logic [N-1:0] d0,
   input  logic [N-1:0] d1,
   input  logic [N-1:0] d2,
   input  logic [N-1:0] d3,
   input  logic [N-1:0] d4,
   input  logic [N-1:0] d5,
   input  logic [N-1:0] d6,
   input  logic [N-1:0] d7,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [N-1:0] out_data,
   output logic [2:0]   out_sel,
   output logic [7:0]   grant,
   output logic [7:0]   ack
);
   typedef enum logic {S_IDLE, S_GRANT} state_t;
   state_t     r_state;
   logic       w_hs;
   logic       w_found;
   logic [2:0] w_start;
   logic [2:0] w_win;
   logic [2:0] w_idx;
   logic [7:0] w_mask;

   assign w_hs = out_valid & out_ready;
   assign ack  = grant & {8{w_hs}};
   // The source being acked is excluded, so it cannot win twice in a row.
   assign w_mask = (r_state == S_IDLE) ? req : (req & ~grant);

`ifdef RR_ARB_FIXED_PRIO_EN
   assign w_start = 3'd0;
`else
   logic [2:0] r_ptr;
   always_ff @(posedge clk)
      if (rst) r_ptr <= 3'd0;
      else if (w_hs) r_ptr <= out_sel + 3'd1;
   assign w_start = (r_state == S_IDLE) ? r_ptr : out_sel + 3'd1;
`endif

   always_comb begin
      w_found = 1'b0;
      w_win   = 3'd0;
      w_idx   = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         w_idx = w_start + 3'(k);
         if (w_mask[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         grant     <= 8'd0;
         out_sel   <= 3'd0;
         out_valid <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (w_found) begin
            r_state   <= S_GRANT;
            grant     <= 8'd1 << w_win;
            out_sel   <= w_win;
            out_valid <= 1'b1;
         end
      end else if (w_hs && w_found) begin
         grant   <= 8'd1 << w_win;
         out_sel <= w_win;
      end else if (w_hs || !req[out_sel]) begin
         r_state   <= S_IDLE;
         grant     <= 8'd0;
         out_valid <= 1'b0;
      end
   end

   mux8_1_n #(.N(N)) u_mux (
      .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
      .sel(out_sel), .y(out_data)
   );
endmodule
